// File: rtl/timebase_stepper_pkg.sv
// Shared direction codes, FSM state type and helpers for the DSO time-base stepper.
package tb_stepper_pkg;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_DEC  = 2'b01;
  localparam logic [1:0] DIR_INC  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  function automatic logic is_step_dir(input logic [1:0] d);
    return (d == DIR_INC) || (d == DIR_DEC);
  endfunction

endpackage

// File: rtl/timebase_stepper_if.sv
// Direction request in, time-base index / restart / decimation strobe out.
interface timebase_stepper_if #(
    parameter int unsigned NUM_BASES = 8
) ();
    localparam int unsigned BW = $clog2(NUM_BASES);

    logic [1:0]    dir;
    logic [BW-1:0] base;
    logic          rst;
    logic          sample_en;

    modport master (output dir, input base, rst, sample_en);
    modport slave  (input dir, output base, rst, sample_en);
endinterface

// File: rtl/timebase_stepper_sample_strobe_gen.sv
// Decimation divider: sample_en fires once every 2^base clocks, restarting on clear.
module sample_strobe_gen #(
    parameter int unsigned NUM_BASES = 8
) (
    input  logic                         clk50,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [$clog2(NUM_BASES)-1:0] base,
    output logic                         sample_en
);
    localparam int unsigned CW = NUM_BASES - 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] mask;

    always_ff @(posedge clk50) begin
        if (reset || clear) cnt <= '0;
        else                cnt <= cnt + CW'(1);
    end

    // Mask selects the low 'base' bits of the counter.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < CW; i++) begin
            if (i < int'(base)) mask[i] = 1'b1;
        end
    end

    assign sample_en = ((cnt & mask) == '0);
endmodule

// File: rtl/timebase_stepper.sv
// Saturating time-base selector with single-step, hold-to-repeat and capture restart pulse.
module timebase_stepper
    import tb_stepper_pkg::*;
#(
    parameter int unsigned NUM_BASES     = 8,
    parameter int unsigned INIT_BASE     = 0,
    parameter int unsigned HOLD_CYCLES   = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
    input logic                clk50,
    input logic                reset,
    timebase_stepper_if.slave  bus
);
    localparam int unsigned BW   = $clog2(NUM_BASES);
    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    prev_dir_q;
    logic [BW-1:0] base_q, base_d;
    logic          rst_q;
    logic          press, step_req, change;

    assign press = is_step_dir(bus.dir) && (bus.dir != prev_dir_q);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TW'(1);
        step_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (press) begin
                    step_req = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (press) begin
                    step_req = 1'b1;
                    timer_d  = '0;
                    state_d  = HOLD;
                end else if (!is_step_dir(bus.dir)) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else if ((state_q == HOLD   && timer_q == TW'(HOLD_CYCLES - 1)) ||
                             (state_q == REPEAT && timer_q == TW'(REPEAT_CYCLES - 1))) begin
                    step_req = 1'b1;
                    timer_d  = '0;
                    state_d  = REPEAT;
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // A step request at a limit still advances the FSM but leaves base untouched.
    always_comb begin
        base_d = base_q;
        change = 1'b0;
        if (step_req) begin
            if (bus.dir == DIR_INC && base_q != BW'(NUM_BASES - 1)) begin
                base_d = base_q + BW'(1);
                change = 1'b1;
            end else if (bus.dir == DIR_DEC && base_q != '0) begin
                base_d = base_q - BW'(1);
                change = 1'b1;
            end
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            prev_dir_q <= DIR_NONE;
            base_q     <= BW'(INIT_BASE);
            rst_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            prev_dir_q <= bus.dir;
            base_q     <= base_d;
            rst_q      <= change;
        end
    end

    sample_strobe_gen #(.NUM_BASES(NUM_BASES)) u_strobe (
        .clk50     (clk50),
        .reset     (reset),
        .clear     (change),
        .base      (base_q),
        .sample_en (bus.sample_en)
    );

    assign bus.base = base_q;
    assign bus.rst  = rst_q;
endmodule

// File: tb/tb_timebase_stepper.sv
// Directed bench for timebase_stepper with short hold/repeat timings.
module tb_timebase_stepper;
    import tb_stepper_pkg::*;

    logic clk50 = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   p;
    int   se_cnt;

    timebase_stepper_if #(.NUM_BASES(8)) bus ();

    timebase_stepper #(
        .NUM_BASES     (8),
        .INIT_BASE     (0),
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (3)
    ) dut (
        .clk50 (clk50),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk50 = ~clk50;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive d for n clocks; count rst pulses and sample_en highs seen after each edge.
    task automatic run(input logic [1:0] d, input int n, output int pulses, output int ses);
        bus.dir = d;
        pulses  = 0;
        ses     = 0;
        repeat (n) begin
            @(posedge clk50);
            #1;
            if (bus.rst)       pulses++;
            if (bus.sample_en) ses++;
        end
    endtask

    initial begin
        bus.dir = DIR_NONE;
        reset   = 1'b1;
        repeat (3) begin
            @(posedge clk50);
            #1;
            check("reset_rst", int'(bus.rst), 1);
        end
        check("reset_base", int'(bus.base), 0);
        check("reset_se", int'(bus.sample_en), 1);
        reset = 1'b0;
        run(DIR_NONE, 4, p, se_cnt);
        check("post_reset_rst", int'(bus.rst), 0);
        check("post_reset_pulses", p, 0);
        check("post_reset_se_every", se_cnt, 4);

        // Single tap, then a short hold
        run(DIR_INC, 1, p, se_cnt);
        check("tap_base", int'(bus.base), 1);
        check("tap_pulses", p, 1);
        run(DIR_NONE, 2, p, se_cnt);
        check("tap_release_pulses", p, 0);
        run(DIR_INC, 5, p, se_cnt);
        check("short_hold_base", int'(bus.base), 2);
        check("short_hold_pulses", p, 1);
        run(DIR_NONE, 2, p, se_cnt);

        // Back to 0, then a decrement tap at the floor
        for (int i = 0; i < 2; i++) begin
            run(DIR_DEC, 1, p, se_cnt);
            run(DIR_NONE, 1, p, se_cnt);
        end
        check("dec_to_zero", int'(bus.base), 0);
        run(DIR_DEC, 1, p, se_cnt);
        check("floor_base", int'(bus.base), 0);
        check("floor_pulses", p, 0);
        run(DIR_NONE, 1, p, se_cnt);

        // Auto-repeat: steps at cycles 0, 8, 11, 14
        run(DIR_INC, 15, p, se_cnt);
        check("repeat_base", int'(bus.base), 4);
        check("repeat_pulses", p, 4);
        run(DIR_NONE, 5, p, se_cnt);
        check("repeat_release_base", int'(bus.base), 4);
        check("repeat_release_pulses", p, 0);

        // Direct 10 -> 01 switch at base 4
        run(DIR_DEC, 1, p, se_cnt);
        run(DIR_NONE, 1, p, se_cnt);
        run(DIR_INC, 3, p, se_cnt);
        check("pre_switch_base", int'(bus.base), 4);
        run(DIR_DEC, 1, p, se_cnt);
        check("switch_base", int'(bus.base), 3);
        check("switch_pulses", p, 1);
        run(DIR_NONE, 2, p, se_cnt);

        // Saturation at the top
        for (int i = 0; i < 4; i++) begin
            run(DIR_INC, 1, p, se_cnt);
            run(DIR_NONE, 1, p, se_cnt);
        end
        check("to_top_base", int'(bus.base), 7);
        run(DIR_INC, 20, p, se_cnt);
        check("top_hold_base", int'(bus.base), 7);
        check("top_hold_pulses", p, 0);
        run(DIR_NONE, 2, p, se_cnt);

        run(2'b11, 10, p, se_cnt);
        check("dir11_base", int'(bus.base), 7);
        check("dir11_pulses", p, 0);
        run(DIR_NONE, 1, p, se_cnt);

        // Decimation at base 3
        for (int i = 0; i < 3; i++) begin
            run(DIR_DEC, 1, p, se_cnt);
            run(DIR_NONE, 1, p, se_cnt);
        end
        bus.dir = DIR_DEC;
        @(posedge clk50);
        #1;
        check("dec3_base", int'(bus.base), 3);
        check("dec3_rst", int'(bus.rst), 1);
        check("dec3_se_k0", int'(bus.sample_en), 1);
        bus.dir = DIR_NONE;
        se_cnt  = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk50);
            #1;
            if (bus.sample_en) se_cnt++;
            if (k == 8 || k == 16) check("dec3_se_k8n", int'(bus.sample_en), 1);
            if (k == 1 || k == 7)  check("dec3_se_off", int'(bus.sample_en), 0);
        end
        check("dec3_se_total", se_cnt, 2);

        // 10 -> 11 -> 10 is a fresh press
        run(DIR_INC, 1, p, se_cnt);
        check("re_press_a", int'(bus.base), 4);
        run(2'b11, 1, p, se_cnt);
        check("re_press_11_pulses", p, 0);
        run(DIR_INC, 1, p, se_cnt);
        check("re_press_b", int'(bus.base), 5);
        check("re_press_b_pulses", p, 1);
        run(DIR_NONE, 1, p, se_cnt);

        // Reset while repeating at base 5, button held through release
        for (int i = 0; i < 3; i++) begin
            run(DIR_DEC, 1, p, se_cnt);
            run(DIR_NONE, 1, p, se_cnt);
        end
        check("pre_rpt_base", int'(bus.base), 2);
        run(DIR_INC, 12, p, se_cnt);
        check("mid_rpt_base", int'(bus.base), 5);
        check("mid_rpt_pulses", p, 3);
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk50);
            #1;
        end
        check("rpt_reset_base", int'(bus.base), 0);
        check("rpt_reset_rst", int'(bus.rst), 1);
        reset = 1'b0;
        @(posedge clk50);
        #1;
        check("held_release_base", int'(bus.base), 1);
        check("held_release_rst", int'(bus.rst), 1);
        @(posedge clk50);
        #1;
        check("held_release_rst_once", int'(bus.rst), 0);
        run(DIR_NONE, 2, p, se_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
